// File: rtl/riscv_pkg.sv
// Shared core-wide definitions: datapath width and the canonical NOP encoding.
// Used by fetch_buffer, decode and the writeback stall logic.
// Pure declarations; no logic.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_buffer.sv
// Instruction/PC queue between fetch and decode, first-word fall-through.
// Latency: a pair pushed at edge N is visible on out_* right after edge N; no empty bypass.
// Backpressure: in_ready depends only on registered count (no path from out_ready); flush overrides both handshakes.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid/in_ready          fetch-side handshake, with in_instr/in_pc payload
//   flush                      drop all entries and any same-cycle push/pop
//   out_valid/out_ready        decode-side handshake, with out_instr/out_pc head payload
//   count                      number of stored entries
module fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = riscv_pkg::XLEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_instr,
  input  logic [XLEN-1:0]          in_pc,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_instr,
  output logic [XLEN-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]   count
);

  import riscv_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Each entry holds {pc, instr}.
  logic [2*XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              push;
  logic              pop;
  logic [2*XLEN-1:0] head;

  // Full/empty come from count only; pointers are free-running and wrap naturally.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);

  // Flush kills both handshakes so neither side sees a transfer in that cycle.
  assign push = in_valid  && in_ready  && !flush;
  assign pop  = out_valid && out_ready && !flush;

  assign head      = mem[rd_ptr];
  assign out_instr = out_valid ? head[XLEN-1:0]      : XLEN'(NOP_INSTR);
  assign out_pc    = out_valid ? head[2*XLEN-1:XLEN] : '0;

  // Storage is not reset; only entries covered by count are ever observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_pc, in_instr};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      // Simultaneous push and pop leave count unchanged.
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [2:0]      count;

  int checks = 0;
  int errors = 0;

  // Scoreboard of stored pairs, each {pc, instr}; index 0 is the expected head.
  logic [63:0] sb [$];

  fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare the pre-edge outputs against the model, update the model with the
  // transfers the current inputs imply, then advance one clock.
  task automatic cycle();
    logic full_m;
    full_m = (sb.size() == DEPTH);
    chk("count",     64'(count),     64'(sb.size()));
    chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    chk("in_ready",  64'(in_ready),  64'(!full_m));
    if (sb.size() == 0) begin
      chk("empty_instr", 64'(out_instr), 64'(NOP));
      chk("empty_pc",    64'(out_pc),    64'd0);
    end else begin
      chk("head_instr", 64'(out_instr), 64'(sb[0][31:0]));
      chk("head_pc",    64'(out_pc),    64'(sb[0][63:32]));
    end
    if (flush) begin
      sb.delete();
    end else begin
      if (out_ready && sb.size() != 0) void'(sb.pop_front());
      if (in_valid && !full_m) sb.push_back({in_pc, in_instr});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] pc);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = 32'hA000_0000 | pc;
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    logic acc;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst_count",   64'(count),     64'd0);
    chk("rst_ovalid",  64'(out_valid), 64'd0);
    chk("rst_iready",  64'(in_ready),  64'd1);
    chk("rst_instr",   64'(out_instr), 64'(NOP));
    chk("rst_pc",      64'(out_pc),    64'd0);

    // Fill with out_ready low, then attempt a fifth push
    for (int i = 0; i < 4; i++) push_one(32'(i * 4));
    chk("full_count",  64'(count),    64'd4);
    chk("full_iready", 64'(in_ready), 64'd0);
    push_one(32'h10);
    chk("full_reject", 64'(count), 64'd4);

    // Drain: expect 0x0, 0x4, 0x8, 0xC in order
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", 64'(out_pc), 64'(i * 4));
      cycle();
    end
    chk("drained_ovalid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Streaming: one cycle of latency, count holds at 1
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_pc     = 32'h0;
    in_instr  = 32'hB000_0000;
    for (int i = 0; i < 20; i++) begin
      acc = (sb.size() != DEPTH);
      cycle();
      if (acc) begin
        if (i > 0) chk("stream_lag", 64'(out_pc), 64'(in_pc));
        in_pc    = in_pc + 32'd4;
        in_instr = 32'hB000_0000 | in_pc;
      end
    end
    chk("stream_count", 64'(count), 64'd1);
    in_valid = 1'b0;
    cycle();
    out_ready = 1'b0;

    // Simultaneous push and pop while full
    for (int i = 0; i < 4; i++) push_one(32'h20 + 32'(i * 4));
    in_valid  = 1'b1;
    in_pc     = 32'h30;
    in_instr  = 32'hC000_0030;
    out_ready = 1'b1;
    cycle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("fullpp_count", 64'(count),  64'd3);
    chk("fullpp_head",  64'(out_pc), 64'h24);

    // Flush with a concurrent push and pop; buffer holds 3 entries here
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_pc     = 32'h40;
    in_instr  = 32'hD000_0040;
    out_ready = 1'b1;
    cycle();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("flush_count",  64'(count),     64'd0);
    chk("flush_ovalid", 64'(out_valid), 64'd0);
    push_one(32'h100);
    chk("post_flush_pc", 64'(out_pc), 64'h100);

    // Asynchronous reset between edges with two entries held
    push_one(32'h200);
    chk("pre_rst_count", 64'(count), 64'd2);
    #2 reset = 1'b1;
    #1;
    chk("arst_count",  64'(count),     64'd0);
    chk("arst_ovalid", 64'(out_valid), 64'd0);
    chk("arst_instr",  64'(out_instr), 64'(NOP));
    chk("arst_iready", 64'(in_ready),  64'd1);
    sb.delete();
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // Random interleaving; fetch holds its pair until accepted
    in_pc    = 32'h1000;
    in_instr = $urandom;
    for (int i = 0; i < 1000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      acc = in_valid && !flush && (sb.size() != DEPTH);
      cycle();
      if (acc) begin
        in_pc    = in_pc + 32'd4;
        in_instr = $urandom;
      end
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + 1) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
